// File: rtl/range_finder_pkg.sv
// Purpose: shared state encoding and mode-aware compare for the range finder stream.
// Latency: n/a (types and a combinational helper only).
// Backpressure: n/a.
package range_finder_pkg;

    typedef enum logic [1:0] {
        RF_IDLE = 2'd0,
        RF_RUN  = 2'd1,
        RF_ERR  = 2'd2
    } rf_state_t;

    // Widest sample the compare helper handles; callers zero-extend into this.
    localparam int unsigned RF_MAX_W = 64;

    // a < b. A signed compare is an unsigned compare with the sign bit (msb)
    // inverted in both operands; bits above msb are zero in both and cancel.
    function automatic logic rf_lt(input logic [RF_MAX_W-1:0] a,
                                   input logic [RF_MAX_W-1:0] b,
                                   input logic                is_signed,
                                   input logic [5:0]          msb);
        logic [RF_MAX_W-1:0] aa;
        logic [RF_MAX_W-1:0] bb;
        aa = a;
        bb = b;
        if (is_signed) begin
            aa[msb] = ~aa[msb];
            bb[msb] = ~bb[msb];
        end
        return (aa < bb);
    endfunction

endpackage

// File: rtl/rf_minmax_track.sv
// Purpose: running min/max/saturating-count registers for one run.
// Latency: registers update on the edge after clr/upd; *_nxt expose the post-edge values now.
// Backpressure: none; every qualified sample is absorbed in its cycle.
module rf_minmax_track
    import range_finder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             upd,
    input  logic             smp_vld,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] smp_dat,
    output logic [WIDTH-1:0] min_nxt,
    output logic [WIDTH-1:0] max_nxt,
    output logic [CNT_W-1:0] cnt_nxt,
    output logic             sat_evt
);

    localparam logic [5:0] MSB = 6'(WIDTH - 1);

    logic [WIDTH-1:0] min_q, min_d;
    logic [WIDTH-1:0] max_q, max_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [RF_MAX_W-1:0] smp_ext, min_ext, max_ext;

    // Zero-extend operands into the helper's fixed compare width.
    always_comb begin
        smp_ext = '0;
        min_ext = '0;
        max_ext = '0;
        smp_ext[WIDTH-1:0] = smp_dat;
        min_ext[WIDTH-1:0] = min_q;
        max_ext[WIDTH-1:0] = max_q;
    end

    // Clear/seed on a run start, otherwise fold in a qualified sample.
    always_comb begin
        min_d   = min_q;
        max_d   = max_q;
        cnt_d   = cnt_q;
        sat_evt = 1'b0;
        if (clr) begin
            min_d = '0;
            max_d = '0;
            cnt_d = '0;
            if (smp_vld) begin
                min_d = smp_dat;
                max_d = smp_dat;
                cnt_d = CNT_W'(1);
            end
        end else if (upd && smp_vld) begin
            if (cnt_q == '0) begin
                min_d = smp_dat;
                max_d = smp_dat;
            end else begin
                if (rf_lt(smp_ext, min_ext, is_signed, MSB)) min_d = smp_dat;
                if (rf_lt(max_ext, smp_ext, is_signed, MSB)) max_d = smp_dat;
            end
            // A sample arriving with the counter already full is one the count loses.
            if (&cnt_q) sat_evt = 1'b1;
            else        cnt_d   = cnt_q + CNT_W'(1);
        end
    end

    // Tracker state registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            min_q <= '0;
            max_q <= '0;
            cnt_q <= '0;
        end else begin
            min_q <= min_d;
            max_q <= max_d;
            cnt_q <= cnt_d;
        end
    end

    assign min_nxt = min_d;
    assign max_nxt = max_d;
    assign cnt_nxt = cnt_d;

endmodule

// File: rtl/range_finder_stream.sv
// Purpose: per-run min/max/range/count over a qualified sample stream between go and finish.
// Latency: result_valid pulses one cycle after the finish cycle; all outputs registered.
// Backpressure: none; samples are taken whenever data_valid is high during a run.
module range_finder_stream
    import range_finder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    input  logic             signed_mode,
    input  logic             go,
    input  logic             finish,
    output logic             busy,
    output logic             result_valid,
    output logic [WIDTH-1:0] range,
    output logic [WIDTH-1:0] min_out,
    output logic [WIDTH-1:0] max_out,
    output logic [CNT_W-1:0] count,
    output logic             overflow,
    output logic             debug_error
);

    rf_state_t        state_q, state_d;
    logic             mode_q, mode_d;
    logic             dbg_q, dbg_d;
    logic             ovf_q, ovf_d;
    logic             rvld_q, rvld_d;
    logic [WIDTH-1:0] range_q, range_d;
    logic [WIDTH-1:0] min_q, min_d;
    logic [WIDTH-1:0] max_q, max_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             trk_clr, trk_upd, trk_sat;
    logic [WIDTH-1:0] trk_min, trk_max;
    logic [CNT_W-1:0] trk_cnt;

    rf_minmax_track #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_track (
        .clock     (clock),
        .reset_n   (reset_n),
        .clr       (trk_clr),
        .upd       (trk_upd),
        .smp_vld   (data_valid),
        .is_signed (mode_q),
        .smp_dat   (data_in),
        .min_nxt   (trk_min),
        .max_nxt   (trk_max),
        .cnt_nxt   (trk_cnt),
        .sat_evt   (trk_sat)
    );

    // Run control: start/restart, sample folding, result capture, protocol errors.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        dbg_d   = dbg_q;
        ovf_d   = ovf_q | trk_sat;
        rvld_d  = 1'b0;
        range_d = range_q;
        min_d   = min_q;
        max_d   = max_q;
        cnt_d   = cnt_q;
        trk_clr = 1'b0;
        trk_upd = 1'b0;
        case (state_q)
            RF_IDLE, RF_ERR: begin
                if (finish) begin
                    state_d = RF_ERR;
                    dbg_d   = 1'b1;
                end else if (go) begin
                    state_d = RF_RUN;
                    trk_clr = 1'b1;
                    mode_d  = signed_mode;
                    dbg_d   = 1'b0;
                    ovf_d   = 1'b0;
                end
            end
            RF_RUN: begin
                if (finish) begin
                    // Fold the finish-cycle sample, then capture from the tracker's next values.
                    trk_upd = 1'b1;
                    state_d = RF_IDLE;
                    rvld_d  = 1'b1;
                    cnt_d   = trk_cnt;
                    if (trk_cnt == '0) begin
                        range_d = '0;
                        min_d   = '0;
                        max_d   = '0;
                        dbg_d   = 1'b1;
                    end else begin
                        // max >= min in the run encoding, so the difference is a
                        // non-negative value below 2^WIDTH; WIDTH-bit wrap is exact.
                        range_d = trk_max - trk_min;
                        min_d   = trk_min;
                        max_d   = trk_max;
                    end
                end else if (go) begin
                    trk_clr = 1'b1;
                    mode_d  = signed_mode;
                    dbg_d   = 1'b1;
                    ovf_d   = 1'b0;
                end else begin
                    trk_upd = 1'b1;
                end
            end
            default: state_d = RF_IDLE;
        endcase
    end

    // Control and result registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RF_IDLE;
            mode_q  <= 1'b0;
            dbg_q   <= 1'b0;
            ovf_q   <= 1'b0;
            rvld_q  <= 1'b0;
            range_q <= '0;
            min_q   <= '0;
            max_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            dbg_q   <= dbg_d;
            ovf_q   <= ovf_d;
            rvld_q  <= rvld_d;
            range_q <= range_d;
            min_q   <= min_d;
            max_q   <= max_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy         = (state_q == RF_RUN);
    assign result_valid = rvld_q;
    assign range        = range_q;
    assign min_out      = min_q;
    assign max_out      = max_q;
    assign count        = cnt_q;
    assign overflow     = ovf_q;
    assign debug_error  = dbg_q;

endmodule

// File: doc/range_finder_stream.md
Name: range_finder_stream

Overview:
Parametrised successor to the single-shot range finder. It accepts a qualified sample stream between go and finish and tracks running min, max, range and sample count. Adds per-run signed/unsigned compare, a valid-qualified input, sticky error/overflow flags and a registered result handshake. It sits between the sample source and any consumer of per-burst statistics.

Parameters:
WIDTH, 16, sample width in bits
CNT_W, 16, width of the accepted-sample counter (saturating)

Ports:
clock  input  1  single clock; all state changes on the rising edge
reset_n  input  1  asynchronous, active-low reset
data_in  input  WIDTH  sample value
data_valid  input  1  data_in is a sample this cycle
signed_mode  input  1  1 = two's-complement compare; sampled only on an accepted go
go  input  1  start a run (or restart one)
finish  input  1  end the run; the valid sample on this cycle is included
busy  output  1  high while a run is in progress
result_valid  output  1  one-cycle pulse when results update
range  output  WIDTH  max - min, unsigned
min_out  output  WIDTH  run minimum, in run encoding
max_out  output  WIDTH  run maximum, in run encoding
count  output  CNT_W  samples accepted in the run (saturating)
overflow  output  1  sticky: count saturated during the last run
debug_error  output  1  sticky protocol error flag

Behaviour:
- Reset (reset_n=0, async): state IDLE. All outputs 0. Internal min/max/count/mode are cleared.
- States: IDLE, RUN, ERR. Next state and register updates are taken at the rising edge.
- IDLE/ERR, finish=1 (regardless of go) -> ERR. Sets debug_error=1. No result_valid pulse. Results unchanged.
- IDLE/ERR, go=1, finish=0 -> RUN:
  - latch signed_mode
  - clear debug_error and overflow
  - if data_valid: min=max=data_in, count=1; else count=0
- RUN, go=1 (finish=0): restart. Same actions as IDLE go, except debug_error is set to 1 (protocol error: go while busy).
- RUN, data_valid=1, finish=0: compare using the latched mode.
  - data_in < min -> min=data_in
  - data_in > max -> max=data_in
  - if count==0, both take data_in
  - count increments and saturates at 2^CNT_W-1; saturation sets overflow=1
- RUN, finish=1 (go ignored): the finish-cycle sample is folded in first, then the result is registered.
  - next cycle: result_valid=1 for exactly one cycle
  - range/min_out/max_out/count are valid and held until the next accepted go
  - state -> IDLE
- Finish with zero accepted samples (including the finish cycle): result_valid still pulses. range/min_out/max_out=0, count=0, debug_error=1.
- Range arithmetic:
  - signed mode: range = max - min computed at WIDTH+1 bits, lower WIDTH bits output (always fits)
  - unsigned mode: plain WIDTH-bit subtraction
- busy=1 exactly when state==RUN (registered).
- Outputs are not combinational on inputs. range/min_out/max_out/count change only at result_valid; they read 0 after reset until the first result.
- reset_n asserted mid-run: abandons the run immediately, all outputs 0.

Decomposition:
- Package range_finder_pkg:
  - state enum rf_state_t {RF_IDLE, RF_RUN, RF_ERR}, logic [1:0]
  - function rf_lt(a, b, is_signed) for mode-aware compare
- One natural sub-module: rf_minmax_track (min/max/count registers with update and clear controls, parametrised by WIDTH and CNT_W).
- The FSM and result registers stay in the top module.

Test Plan:
- WIDTH=8, unsigned: go+valid 10, then valid 3, 200, 50, finish+valid 7 -> one cycle later result_valid=1, min_out=3, max_out=200, range=197, count=5, debug_error=0.
- Signed: go with signed_mode=1, samples 8'hF6(-10), 8'h14(20), finish+valid 8'h05 -> min_out=8'hF6, max_out=8'h14, range=30. Same stream unsigned -> min=5, max=246, range=241.
- finish in IDLE -> ERR, debug_error=1, no result_valid. Then go+valid 4, finish+valid 9 -> range=5, debug_error=0.
- go with data_valid=0, then finish with data_valid=0 -> result_valid pulse, count=0, range=0, debug_error=1.
- CNT_W=2: go+valid, 5 more valid samples, finish -> count=3, overflow=1. The next go clears overflow.
- Mid-run go (samples 1, 100 then go+valid 50, finish+valid 60) -> range=10, count=2, debug_error=1. Separately, reset_n pulse mid-run -> busy=0, all outputs 0 asynchronously.
